bisection_search_ctrl: RTL

//  Next-generation bisection controller for the Q-tuning loop. Searches i_ref within a
//  run-time [lo_bound,hi_bound] window until |measured_q - desired_q| <= TOL.

---
 rtl/bisection_search_ctrl_if.sv | 32 +++
 rtl/bisection_search_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bisection_search_ctrl_if.sv
// Handshake/bus bundle between the control sequencer (master) and the
// bisection controller (slave), including the bias-DAC and Q-ADC sides.
interface bisection_search_ctrl_if #(
  parameter int WIDTH    = 10,
  parameter int MAX_ITER = 12
);
  localparam int IW = $clog2(MAX_ITER + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo_bound;
  logic [WIDTH-1:0] hi_bound;
  logic [WIDTH-1:0] desired_q;
  logic [WIDTH-1:0] measured_q;
  logic             meas_valid;
  logic [WIDTH-1:0] i_ref;
  logic             busy;
  logic             done;
  logic             converged;
  logic             fail;
  logic [IW-1:0]    iter_cnt;

  modport master (
    output start, abort, lo_bound, hi_bound, desired_q, measured_q, meas_valid,
    input  i_ref, busy, done, converged, fail, iter_cnt
  );

  modport slave (
    input  start, abort, lo_bound, hi_bound, desired_q, measured_q, meas_valid,
    output i_ref, busy, done, converged, fail, iter_cnt
  );
endinterface

// File: rtl/bisection_search_ctrl.sv
// Bisection search of i_ref within [lo_bound,hi_bound] until |measured_q-desired_q| <= TOL.
// Optional macro BISECT_TRACK_EN: after convergence, keep watching Q and auto-restart on drift.
module bisection_search_ctrl #(
  parameter int WIDTH    = 10,
  parameter int TOL      = 30,
  parameter int MAX_ITER = 12,
  parameter int SETTLE   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bisection_search_ctrl_if.slave  bus
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef BISECT_TRACK_EN
  localparam logic [2:0] S_TRACK = 3'd5;
  localparam logic [WIDTH:0] TOL2_C = (WIDTH+1)'(2 * TOL);
`endif

  localparam logic [WIDTH:0]   TOL_C    = (WIDTH+1)'(TOL);
  localparam logic [IW-1:0]    MAX_C    = IW'(MAX_ITER);
  localparam logic [SW-1:0]    SETTLE_C = SW'(SETTLE);

  // Midpoint in WIDTH+1 bits so a+b never overflows.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return WIDTH'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  function automatic logic [WIDTH:0] abs_err(input logic [WIDTH-1:0] m,
                                             input logic [WIDTH-1:0] q);
    logic signed [WIDTH:0] d;
    d = $signed({1'b0, m}) - $signed({1'b0, q});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_iref;
  logic [WIDTH-1:0] r_meas;
  logic [SW-1:0]    r_settle;
  logic [IW-1:0]    r_iter;
  logic             r_busy;
  logic             r_done;
  logic             r_conv;
  logic             r_fail;
`ifdef BISECT_TRACK_EN
  logic [WIDTH-1:0] r_lo_s;
  logic [WIDTH-1:0] r_hi_s;
  logic [WIDTH:0]   w_err_live;
`endif

  logic [WIDTH-1:0] w_mid;
  logic [WIDTH:0]   w_err_eval;
  logic [IW-1:0]    w_iter_nx;
  logic [WIDTH-1:0] w_span;
  logic             w_rest;
  logic             w_accept;
  logic             w_abort;

  assign w_mid      = midpoint(r_a, r_b);
  assign w_err_eval = abs_err(r_meas, bus.desired_q);
  assign w_iter_nx  = r_iter + IW'(1);
  assign w_span     = r_b - r_a;

`ifdef BISECT_TRACK_EN
  assign w_err_live = abs_err(bus.measured_q, bus.desired_q);
  assign w_rest     = (r_state == S_IDLE) || (r_state == S_TRACK);
  assign w_abort    = bus.abort && ((r_state == S_DRIVE) || (r_state == S_WAIT) ||
                                    (r_state == S_EVAL)  || (r_state == S_TRACK));
`else
  assign w_rest     = (r_state == S_IDLE);
  assign w_abort    = bus.abort && ((r_state == S_DRIVE) || (r_state == S_WAIT) ||
                                    (r_state == S_EVAL));
`endif
  // Abort outranks a simultaneous start.
  assign w_accept = w_rest && bus.start && !bus.abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_iref   <= '0;
      r_settle <= '0;
      r_iter   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_conv   <= 1'b0;
      r_fail   <= 1'b0;
`ifdef BISECT_TRACK_EN
      r_lo_s   <= '0;
      r_hi_s   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (w_accept) begin
        r_a    <= bus.lo_bound;
        r_b    <= bus.hi_bound;
        r_iter <= '0;
        r_conv <= 1'b0;
`ifdef BISECT_TRACK_EN
        r_lo_s <= bus.lo_bound;
        r_hi_s <= bus.hi_bound;
`endif
        if (bus.lo_bound > bus.hi_bound) begin
          r_fail  <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_fail  <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_DRIVE;
        end
      end else begin
        case (r_state)
          S_DRIVE: begin
            r_iref   <= w_mid;
            r_settle <= SETTLE_C;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            if (r_settle != '0) begin
              r_settle <= r_settle - SW'(1);
            end else if (bus.meas_valid) begin
              r_state <= S_EVAL;
            end
          end
          S_EVAL: begin
            r_iter <= w_iter_nx;
            if (w_err_eval <= TOL_C) begin
              r_conv  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if ((w_iter_nx == MAX_C) || (w_span <= WIDTH'(1))) begin
              r_fail  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Monotonic plant: Q too low means the answer lies above i_ref.
              if (bus.desired_q > r_meas) r_a <= r_iref;
              else                        r_b <= r_iref;
              r_state <= S_DRIVE;
            end
          end
`ifdef BISECT_TRACK_EN
          S_DONE: r_state <= r_conv ? S_TRACK : S_IDLE;
          S_TRACK: begin
            if (bus.meas_valid && (w_err_live > TOL2_C)) begin
              r_a     <= r_lo_s;
              r_b     <= r_hi_s;
              r_iter  <= '0;
              r_conv  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_DRIVE;
            end
          end
`else
          S_DONE: r_state <= S_IDLE;
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Measurement capture register; data only, so no reset.
  always_ff @(posedge clk) begin
    if ((r_state == S_WAIT) && (r_settle == '0) && bus.meas_valid)
      r_meas <= bus.measured_q;
  end

  assign bus.i_ref     = r_iref;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.converged = r_conv;
  assign bus.fail      = r_fail;
  assign bus.iter_cnt  = r_iter;

endmodule
